// File: rtl/address_generator_o_tiled_if.sv
// address_generator_o_tiled_if: job control and per-lane RAM_O write bus of the tiled output address generator
interface address_generator_o_tiled_if #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int MAX_DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M,
  parameter int DEPTH_WIDTH = $clog2(MAX_DEPTH) + 1
);
  logic start;
  logic [$clog2(ARRAY_M):0] num_cols;
  logic [DEPTH_WIDTH-1:0] depth;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic acc_mode;
  logic stall;
  logic busy;
  logic done;
  logic [ADDR_SET_WIDTH-1:0] addr_set;
  logic [ARRAY_M-1:0] enable_set;
  logic [ARRAY_M-1:0] acc_set;
  modport master (
    output start, num_cols, depth, base_addr, stride, acc_mode, stall,
    input busy, done, addr_set, enable_set, acc_set
  );
  modport slave (
    input start, num_cols, depth, base_addr, stride, acc_mode, stall,
    output busy, done, addr_set, enable_set, acc_set
  );
endinterface

// File: rtl/address_generator_o_tiled.sv
// address_generator_o_tiled: skewed per-column RAM_O write addresses with stride, wrap, stall and accumulate flag
module address_generator_o_tiled #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int MAX_DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M,
  parameter int DEPTH_WIDTH = $clog2(MAX_DEPTH) + 1
) (
  input logic clk,
  input logic reset,
  address_generator_o_tiled_if.slave bus
);
  localparam int CW = $clog2(ARRAY_M) + 1;
  localparam int TW = DEPTH_WIDTH + CW;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] ncols, ncols_in;
  logic [DEPTH_WIDTH-1:0] dep;
  logic [ADDR_WIDTH-1:0] base, strd;
  logic accm, go, issue, fin, busy_q, done_q;
  logic [TW-1:0] t, t_end;
  logic [ARRAY_M-1:0] en_nx, en_q, acc_q;
  logic [ADDR_SET_WIDTH-1:0] addr_q;
  // t is the next step to issue; step 0 goes out on the start edge itself
  always_comb begin
    ncols_in = bus.num_cols > CW'(ARRAY_M) ? CW'(ARRAY_M) : bus.num_cols;
    t_end = TW'(ncols) + TW'(dep) - TW'(2);
    go = state == IDLE && bus.start && bus.num_cols != '0 && bus.depth != '0;
    issue = state == RUN && !bus.stall && t <= t_end;
    fin = state == RUN && !bus.stall && t > t_end;
    state_nx = state == DONE ? IDLE : fin ? DONE : state == IDLE && bus.start ? (go ? RUN : DONE) : state;
    en_nx = '0;
    for (int j = 0; j < ARRAY_M; j++)
      en_nx[j] = TW'(j) < TW'(ncols) && t >= TW'(j) && t - TW'(j) < TW'(dep);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ncols <= '0;
      dep <= '0;
      base <= '0;
      strd <= '0;
      accm <= 1'b0;
      t <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      en_q <= '0;
      acc_q <= '0;
      addr_q <= '0;
    end else begin
      busy_q <= state_nx == RUN;
      done_q <= state_nx == DONE;
      en_q <= go ? ARRAY_M'(1) : issue ? en_nx : '0;
      acc_q <= go ? ARRAY_M'(bus.acc_mode) : issue ? en_nx & {ARRAY_M{accm}} : '0;
      if (state == IDLE && bus.start) begin
        ncols <= ncols_in;
        dep <= bus.depth;
        base <= bus.base_addr;
        strd <= bus.stride;
        accm <= bus.acc_mode;
      end
      t <= go ? TW'(1) : issue ? t + TW'(1) : t;
      if (go) addr_q[0 +: ADDR_WIDTH] <= bus.base_addr;
      // lane j reaches row 0 exactly at step j, after that it accumulates the stride
      for (int j = 0; j < ARRAY_M; j++)
        if (issue && en_nx[j])
          addr_q[j*ADDR_WIDTH +: ADDR_WIDTH] <= t == TW'(j) ? base : addr_q[j*ADDR_WIDTH +: ADDR_WIDTH] + strd;
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.enable_set = en_q;
  assign bus.acc_set = acc_q;
  assign bus.addr_set = addr_q;
endmodule
